fp_div_seq: RTL and testbench

FP_DIV_SEQ -- requirements
Module: fp_div_seq

---
 rtl/fp_pkg.sv | 40 ++++
 rtl/fp_classify.sv | 23 ++
 rtl/fp_div_seq.sv | 203 ++++++++++++++++++++
 tb/tb_fp_div_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision constants, FSM state type and the divider step helper.
package fp_pkg;

   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int MANT_W = 24;
   localparam int QUO_W  = 25;
   localparam int EXPR_W = 10;
   localparam int CNT_W  = 5;
   localparam int REM_W  = MANT_W + 2;

   localparam logic signed [EXPR_W-1:0] BIAS    = 10'sd127;
   localparam logic signed [EXPR_W-1:0] EXP_MAX = 10'sd255;
   localparam logic [31:0]              QNAN    = 32'h7FC00000;
   localparam logic [31:0]              POS_INF = 32'h7F800000;

   // Iterations remaining after the first quotient bit is resolved in UNPACK.
   localparam logic [CNT_W-1:0] DIV_ITERS_LEFT = 5'd23;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      UNPACK = 3'd1,
      DIVIDE = 3'd2,
      PACK   = 3'd3,
      DONE   = 3'd4
   } state_t;

   // One restoring-division step: returns {quotient_bit, next_partial_remainder}.
   function automatic logic [REM_W:0] div_step(input logic [REM_W-1:0] rem,
                                               input logic [MANT_W-1:0] dvs);
      logic [REM_W-1:0] diff;
      diff = rem - {2'b00, dvs};
      if (rem >= {2'b00, dvs}) begin
         div_step = {1'b1, diff[REM_W-2:0], 1'b0};
      end else begin
         div_step = {1'b0, rem[REM_W-2:0], 1'b0};
      end
   endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single operand classifier; denormals report as zero.
module fp_classify
   import fp_pkg::*;
(
   input  logic [31:0] op,
   output logic        is_zero,
   output logic        is_inf,
   output logic        is_nan
);

   logic exp_ones_s;
   logic exp_zero_s;
   logic frac_zero_s;

   assign exp_ones_s  = &op[FRAC_W +: EXP_W];
   assign exp_zero_s  = ~|op[FRAC_W +: EXP_W];
   assign frac_zero_s = ~|op[FRAC_W-1:0];

   assign is_zero = exp_zero_s;
   assign is_inf  = exp_ones_s & frac_zero_s;
   assign is_nan  = exp_ones_s & ~frac_zero_s;

endmodule

// File: rtl/fp_div_seq.sv
// Sequential single-precision divider: restoring division, one quotient bit
// per cycle, truncating rounding, flush-to-zero on underflow.
module fp_div_seq
   import fp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        overflow,
   output logic        underflow,
   output logic        div_by_zero
);

   state_t                    state_r, next_state_s;
   logic [31:0]               a_r, b_r;
   logic [CNT_W-1:0]          cnt_r;
   logic [REM_W-1:0]          rem_r;
   logic [QUO_W-1:0]          quo_r;
   logic signed [EXPR_W-1:0]  exp_r;
   logic                      sign_r;
   logic [31:0]               pend_res_r;
   logic                      pend_ovf_r, pend_udf_r, pend_dbz_r;
   logic                      busy_r, done_r, ovf_r, udf_r, dbz_r;
   logic [31:0]               result_r;

   logic                      a_zero_s, a_inf_s, a_nan_s;
   logic                      b_zero_s, b_inf_s, b_nan_s;
   logic                      sign_s;
   logic [MANT_W-1:0]         ma_s, mb_s;
   logic                      spec_s, spec_dbz_s;
   logic [31:0]               spec_res_s;
   logic [REM_W-1:0]          step_in_s;
   logic [REM_W:0]            step_out_s;
   logic signed [EXPR_W-1:0]  pack_exp_s;
   logic [FRAC_W-1:0]         pack_frac_s;
   logic [31:0]               pack_res_s;
   logic                      pack_ovf_s, pack_udf_s;

   fp_classify u_cls_a (.op(a_r), .is_zero(a_zero_s), .is_inf(a_inf_s), .is_nan(a_nan_s));
   fp_classify u_cls_b (.op(b_r), .is_zero(b_zero_s), .is_inf(b_inf_s), .is_nan(b_nan_s));

   assign sign_s = a_r[31] ^ b_r[31];
   assign ma_s   = {1'b1, a_r[FRAC_W-1:0]};
   assign mb_s   = {1'b1, b_r[FRAC_W-1:0]};

   // Special-operand results, resolved in UNPACK without running the divider.
   always_comb begin
      spec_s     = 1'b1;
      spec_res_s = 32'h00000000;
      spec_dbz_s = 1'b0;
      if (a_nan_s | b_nan_s | (a_zero_s & b_zero_s) | (a_inf_s & b_inf_s)) begin
         spec_res_s = QNAN;
      end else if (b_zero_s) begin
         spec_res_s = POS_INF | {sign_s, 31'h00000000};
         spec_dbz_s = ~a_inf_s;
      end else if (a_inf_s) begin
         spec_res_s = POS_INF | {sign_s, 31'h00000000};
      end else if (b_inf_s | a_zero_s) begin
         spec_res_s = {sign_s, 31'h00000000};
      end else begin
         spec_s = 1'b0;
      end
   end

   // Divider step input: mantissa of A on the first bit, partial remainder after.
   always_comb begin
      if (state_r == UNPACK) begin
         step_in_s = {2'b00, ma_s};
      end else begin
         step_in_s = rem_r;
      end
      step_out_s = div_step(step_in_s, mb_s);
   end

   // Normalise the quotient, truncate the guard bit and apply exponent limits.
   always_comb begin
      if (quo_r[QUO_W-1]) begin
         pack_frac_s = quo_r[QUO_W-2:1];
         pack_exp_s  = exp_r;
      end else begin
         pack_frac_s = quo_r[QUO_W-3:0];
         pack_exp_s  = exp_r - 10'sd1;
      end
      pack_ovf_s = 1'b0;
      pack_udf_s = 1'b0;
      if (pack_exp_s >= EXP_MAX) begin
         pack_res_s = POS_INF | {sign_r, 31'h00000000};
         pack_ovf_s = 1'b1;
      end else if (pack_exp_s <= 10'sd0) begin
         pack_res_s = {sign_r, 31'h00000000};
         pack_udf_s = 1'b1;
      end else begin
         pack_res_s = {sign_r, pack_exp_s[EXP_W-1:0], pack_frac_s};
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // FSM next-state decode; start is only honoured in IDLE.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE:    if (start) next_state_s = UNPACK; else next_state_s = IDLE;
         UNPACK:  if (spec_s) next_state_s = DONE; else next_state_s = DIVIDE;
         DIVIDE:  if (cnt_r == 5'd0) next_state_s = PACK; else next_state_s = DIVIDE;
         PACK:    next_state_s = DONE;
         DONE:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // Datapath: operand capture, iteration, packing and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r        <= 32'h00000000;
         b_r        <= 32'h00000000;
         cnt_r      <= 5'd0;
         rem_r      <= '0;
         quo_r      <= '0;
         exp_r      <= 10'sd0;
         sign_r     <= 1'b0;
         pend_res_r <= 32'h00000000;
         pend_ovf_r <= 1'b0;
         pend_udf_r <= 1'b0;
         pend_dbz_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         result_r   <= 32'h00000000;
         ovf_r      <= 1'b0;
         udf_r      <= 1'b0;
         dbz_r      <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  a_r    <= A;
                  b_r    <= B;
                  busy_r <= 1'b1;
                  ovf_r  <= 1'b0;
                  udf_r  <= 1'b0;
                  dbz_r  <= 1'b0;
               end
            end
            UNPACK: begin
               sign_r     <= sign_s;
               pend_res_r <= spec_res_s;
               pend_ovf_r <= 1'b0;
               pend_udf_r <= 1'b0;
               pend_dbz_r <= spec_dbz_s;
               exp_r      <= $signed({2'b00, a_r[30:23]}) - $signed({2'b00, b_r[30:23]}) + BIAS;
               rem_r      <= step_out_s[REM_W-1:0];
               quo_r      <= {{(QUO_W-1){1'b0}}, step_out_s[REM_W]};
               cnt_r      <= DIV_ITERS_LEFT;
            end
            DIVIDE: begin
               rem_r <= step_out_s[REM_W-1:0];
               quo_r <= {quo_r[QUO_W-2:0], step_out_s[REM_W]};
               if (cnt_r != 5'd0) begin
                  cnt_r <= cnt_r - 5'd1;
               end
            end
            PACK: begin
               pend_res_r <= pack_res_s;
               pend_ovf_r <= pack_ovf_s;
               pend_udf_r <= pack_udf_s;
               pend_dbz_r <= 1'b0;
            end
            DONE: begin
               result_r <= pend_res_r;
               ovf_r    <= pend_ovf_r;
               udf_r    <= pend_udf_r;
               dbz_r    <= pend_dbz_r;
               done_r   <= 1'b1;
               busy_r   <= 1'b0;
            end
            default: begin
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = busy_r;
   assign done        = done_r;
   assign result      = result_r;
   assign overflow    = ovf_r;
   assign underflow   = udf_r;
   assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: scoreboard of expected results and done times.
module tb_fp_div_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] a_s, b_s;
   logic        busy, done, overflow, underflow, div_by_zero;
   logic [31:0] result;

   typedef struct {
      logic [31:0] res;
      logic        ovf;
      logic        udf;
      logic        dbz;
      int          due;
   } sb_entry_t;

   sb_entry_t sb[$];
   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   fp_div_seq dut (
      .clk(clk), .rst_n(rst_n), .start(start), .A(a_s), .B(b_s),
      .busy(busy), .done(done), .result(result), .overflow(overflow),
      .underflow(underflow), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   // Cycle counter used for latency expectations.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: truncated quotient from a wide integer divide.
   function automatic sb_entry_t model_normal(input logic [31:0] a, input logic [31:0] b);
      sb_entry_t   e;
      logic [63:0] q;
      logic [22:0] frac;
      int          ex;
      logic        sg;
      sg = a[31] ^ b[31];
      q  = ({40'd0, 1'b1, a[22:0]} << 24) / {40'd0, 1'b1, b[22:0]};
      ex = int'(a[30:23]) - int'(b[30:23]) + 127;
      if (q[24]) frac = q[23:1];
      else begin frac = q[22:0]; ex = ex - 1; end
      e.ovf = 1'b0; e.udf = 1'b0; e.dbz = 1'b0; e.due = 0;
      if (ex >= 255) begin e.res = {sg, 31'h7F800000}; e.ovf = 1'b1; end
      else if (ex <= 0) begin e.res = {sg, 31'h0}; e.udf = 1'b1; end
      else e.res = {sg, ex[7:0], frac};
      return e;
   endfunction

   // Scoreboard consumer: compare every done pulse against the oldest expectation.
   initial begin
      sb_entry_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && done) begin
            if (sb.size() == 0) begin
               check_eq("spurious_done", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check_eq("result", result, e.res);
               check_eq("flags", {29'd0, overflow, underflow, div_by_zero},
                        {29'd0, e.ovf, e.udf, e.dbz});
               check_eq("latency", cyc, e.due);
               check_eq("busy_at_done", {31'd0, busy}, 32'd0);
            end
         end
      end
   end

   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                        input logic ovf, input logic udf, input logic dbz,
                        input int lat, input bit poke);
      sb_entry_t e;
      @(negedge clk);
      a_s = a; b_s = b; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      e.res = r; e.ovf = ovf; e.udf = udf; e.dbz = dbz; e.due = cyc + lat;
      sb.push_back(e);
      for (int n = 0; n < 60 && sb.size() != 0; n++) begin
         @(posedge clk);
         #2;
         if (poke && n == 4) begin
            check_eq("busy_mid", {31'd0, busy}, 32'd1);
            a_s = 32'h3F800000; b_s = 32'h00000000; start = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      if (sb.size() != 0) begin
         check_eq("timeout", sb.size(), 32'd0);
         sb.delete();
      end
   endtask

   task automatic do_norm(input logic [31:0] a, input logic [31:0] b);
      sb_entry_t m;
      m = model_normal(a, b);
      do_op(a, b, m.res, m.ovf, m.udf, m.dbz, 27, 1'b0);
   endtask

   initial begin
      logic [31:0] ra, rb;
      rst_n = 1'b0; start = 1'b0; a_s = 32'h0; b_s = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_outputs", {26'd0, busy, done, overflow, underflow, div_by_zero, 1'b0}, 32'd0);
      check_eq("rst_result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Normal operands
      do_op(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0, 27, 1'b0);
      repeat (3) @(posedge clk);
      #1 check_eq("result_hold", result, 32'h40400000);
      do_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 1'b0, 1'b0, 27, 1'b0);
      do_op(32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 1'b0, 1'b0, 27, 1'b0);
      do_op(32'h3FC00000, 32'h3F800000, 32'h3FC00000, 1'b0, 1'b0, 1'b0, 27, 1'b0);
      // Exponent limits
      do_op(32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b1, 1'b0, 1'b0, 27, 1'b0);
      do_op(32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 27, 1'b0);
      // Special operands
      do_op(32'h40000000, 32'h00000000, 32'h7F800000, 1'b0, 1'b0, 1'b1, 2, 1'b0);
      do_op(32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0, 1'b0, 2, 1'b0);
      do_op(32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b0, 1'b0, 1'b0, 2, 1'b0);
      do_op(32'h3F800000, 32'hFF800000, 32'h80000000, 1'b0, 1'b0, 1'b0, 2, 1'b0);
      do_op(32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b0, 1'b0, 2, 1'b0);
      do_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0, 1'b0, 2, 1'b0);
      do_op(32'h00000000, 32'h7FA00000, 32'h7FC00000, 1'b0, 1'b0, 1'b0, 2, 1'b0);
      do_op(32'h80000001, 32'h40000000, 32'h80000000, 1'b0, 1'b0, 1'b0, 2, 1'b0);
      do_op(32'hC0000000, 32'h00000005, 32'hFF800000, 1'b0, 1'b0, 1'b1, 2, 1'b0);

      // Random normal operands against the wide-divide reference
      for (int i = 0; i < 8; i++) begin
         ra = {1'($urandom_range(1, 0)), 8'($urandom_range(190, 60)), 23'($urandom)};
         rb = {1'($urandom_range(1, 0)), 8'($urandom_range(190, 60)), 23'($urandom)};
         do_norm(ra, rb);
      end

      // Abort mid-divide with reset; no done may follow for that operation
      @(negedge clk);
      a_s = 32'h40C00000; b_s = 32'h40000000; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check_eq("abort_outputs", {27'd0, busy, done, overflow, underflow, div_by_zero}, 32'd0);
      check_eq("abort_result", result, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      a_s = 32'h40C00000; b_s = 32'h40000000; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      sb.push_back('{res: 32'h40400000, ovf: 1'b0, udf: 1'b0, dbz: 1'b0, due: cyc + 27});
      for (int n = 0; n < 60 && sb.size() != 0; n++) @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         check_eq("timeout_after_reset", sb.size(), 32'd0);
         sb.delete();
      end

      // Start pulsed while busy is ignored
      do_op(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0, 27, 1'b1);
      repeat (40) @(posedge clk);
      #1 check_eq("no_extra_op", {31'd0, busy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog so the run can never hang.
   initial begin
      #500000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
